// File: rtl/tlb_mgmt_unit_if.sv
// Port bundle for tlb_mgmt_unit: two search ports, write/fill, read and invalidate handshake.
// The DUT attaches via the slave modport; the driving side uses master.
interface tlb_mgmt_unit_if;
    logic [18:0] s0_vppn;
    logic        s0_va_bit12;
    logic [9:0]  s0_asid;
    logic [36:0] s0_result;
    logic [18:0] s1_vppn;
    logic        s1_va_bit12;
    logic [9:0]  s1_asid;
    logic [36:0] s1_result;
    logic        w_req;
    logic        fill_req;
    logic [3:0]  w_index;
    logic [88:0] w_entry;
    logic        w_ready;
    logic [3:0]  r_index;
    logic [88:0] r_entry;
    logic        inv_valid;
    logic [4:0]  inv_op;
    logic [9:0]  inv_asid;
    logic [18:0] inv_vppn;
    logic        inv_ready;
    logic        inv_done;

    modport slave (
        input  s0_vppn, s0_va_bit12, s0_asid, s1_vppn, s1_va_bit12, s1_asid,
        input  w_req, fill_req, w_index, w_entry, r_index,
        input  inv_valid, inv_op, inv_asid, inv_vppn,
        output s0_result, s1_result, w_ready, r_entry, inv_ready, inv_done
    );

    modport master (
        output s0_vppn, s0_va_bit12, s0_asid, s1_vppn, s1_va_bit12, s1_asid,
        output w_req, fill_req, w_index, w_entry, r_index,
        output inv_valid, inv_op, inv_asid, inv_vppn,
        input  s0_result, s1_result, w_ready, r_entry, inv_ready, inv_done
    );
endinterface

// File: rtl/tlb_mgmt_unit.sv
// TLB array with two combinational search ports, tlbwr/tlbfill write path, tlbrd read port
// and a sequential invtlb sweep that clears one entry per cycle.
module tlb_mgmt_unit #(
    parameter int TLBNUM = 16
) (
    input logic           clk,
    input logic           resetn,
    tlb_mgmt_unit_if.slave bus
);
    localparam int IW = $clog2(TLBNUM);

    typedef struct packed {
        logic        e;
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic [9:0]  asid;
        logic        g;
        logic [19:0] ppn0;
        logic [1:0]  plv0;
        logic [1:0]  mat0;
        logic        d0;
        logic        v0;
        logic [19:0] ppn1;
        logic [1:0]  plv1;
        logic [1:0]  mat1;
        logic        d1;
        logic        v1;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    entry_t          ent_q [TLBNUM];
    logic [IW-1:0]   fill_ptr_q;
    logic [IW-1:0]   fill_ptr_d;
    logic [IW-1:0]   ptr_q;
    state_e          state_q;
    logic [4:0]      op_q;
    logic [9:0]      asid_q;
    logic [18:0]     vppn_q;
    logic            inv_ready_q;
    logic            inv_done_q;
    logic            wr_accept_s;
    logic [IW-1:0]   wr_idx_s;
    entry_t          cur_s;
    logic            asid_eq_s;
    logic            vppn_eq_s;
    logic            inv_hit_s;

    // 4 KiB pages compare the full VPPN; larger pages ignore the low 9 bits.
    function automatic logic vppn_eq(input entry_t en, input logic [18:0] key);
        return (en.ps == 6'd12) ? (en.vppn == key) : (en.vppn[18:9] == key[18:9]);
    endfunction

    // Scan downward so the lowest matching index is the one left in the result.
    function automatic logic [36:0] search(input logic [18:0] kv, input logic kb, input logic [9:0] ka);
        logic [36:0] res;
        logic        odd;
        entry_t      en;
        res = 37'd0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            en = ent_q[i];
            if (en.e && (en.g || (en.asid == ka)) && vppn_eq(en, kv)) begin
                odd = (en.ps == 6'd12) ? kb : en.vppn[8];
                res = odd ? {1'b1, 4'(i), en.ppn1, en.ps, en.plv1, en.mat1, en.d1, en.v1}
                          : {1'b1, 4'(i), en.ppn0, en.ps, en.plv0, en.mat0, en.d0, en.v0};
            end
        end
        return res;
    endfunction

    // Search ports and read port are combinational views of the array.
    always_comb begin
        bus.s0_result = search(bus.s0_vppn, bus.s0_va_bit12, bus.s0_asid);
        bus.s1_result = search(bus.s1_vppn, bus.s1_va_bit12, bus.s1_asid);
        bus.r_entry   = ent_q[IW'(bus.r_index)];
    end

    assign bus.w_ready   = inv_ready_q;
    assign bus.inv_ready = inv_ready_q;
    assign bus.inv_done  = inv_done_q;

    // Write acceptance; fill takes the round-robin slot and wins over tlbwr.
    always_comb begin
        wr_accept_s = (bus.w_req || bus.fill_req) && inv_ready_q;
        wr_idx_s    = bus.fill_req ? fill_ptr_q : IW'(bus.w_index);
        if (bus.fill_req && inv_ready_q) begin
            fill_ptr_d = fill_ptr_q + IW'(1);
        end else begin
            fill_ptr_d = fill_ptr_q;
        end
    end

    // Invalidate match for the entry under the sweep pointer.
    always_comb begin
        cur_s     = ent_q[ptr_q];
        asid_eq_s = (cur_s.asid == asid_q);
        vppn_eq_s = vppn_eq(cur_s, vppn_q);
        case (op_q)
            5'd0, 5'd1: inv_hit_s = 1'b1;
            5'd2:       inv_hit_s = cur_s.g;
            5'd3:       inv_hit_s = !cur_s.g;
            5'd4:       inv_hit_s = !cur_s.g && asid_eq_s;
            5'd5:       inv_hit_s = !cur_s.g && asid_eq_s && vppn_eq_s;
            5'd6:       inv_hit_s = (cur_s.g || asid_eq_s) && vppn_eq_s;
            default:    inv_hit_s = 1'b0;
        endcase
    end

    // Entry array and fill pointer: writes only in IDLE, sweep clears only in SWEEP.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < TLBNUM; i++) begin
                ent_q[i] <= '0;
            end
            fill_ptr_q <= '0;
        end else begin
            if (wr_accept_s) begin
                ent_q[wr_idx_s] <= bus.w_entry;
            end
            if ((state_q == ST_SWEEP) && inv_hit_s) begin
                ent_q[ptr_q].e <= 1'b0;
            end
            fill_ptr_q <= fill_ptr_d;
        end
    end

    // Invalidate sequencer with registered ready/done outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            op_q        <= 5'd0;
            asid_q      <= 10'd0;
            vppn_q      <= 19'd0;
            inv_ready_q <= 1'b1;
            inv_done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.inv_valid) begin
                        inv_ready_q <= 1'b0;
                        if (bus.inv_op <= 5'd6) begin
                            state_q <= ST_SWEEP;
                            ptr_q   <= '0;
                            op_q    <= bus.inv_op;
                            asid_q  <= bus.inv_asid;
                            vppn_q  <= bus.inv_vppn;
                        end else begin
                            state_q    <= ST_DONE;
                            inv_done_q <= 1'b1;
                        end
                    end
                end
                ST_SWEEP: begin
                    ptr_q <= ptr_q + IW'(1);
                    if (ptr_q == IW'(TLBNUM - 1)) begin
                        state_q    <= ST_DONE;
                        inv_done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    inv_done_q  <= 1'b0;
                    inv_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    inv_done_q  <= 1'b0;
                    inv_ready_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/tlb_mgmt_unit.md
TLB_MGMT_UNIT -- requirements
Module: tlb_mgmt_unit

Interface
REQ-001 Parameter: TLBNUM, default 16, number of TLB entries (index width 4).
REQ-002 Reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  system clock.
REQ-004 resetn  in  1  asynchronous active-low reset.
REQ-005 s0_vppn/s0_va_bit12/s0_asid  in  19/1/10  fetch search key.
REQ-006 s0_result  out  37  {found, index[3:0], ppn[19:0], ps[5:0], plv[1:0], mat[1:0], d, v}.
REQ-007 s1_vppn/s1_va_bit12/s1_asid  in  19/1/10  data/tlbsrch search key.
REQ-008 s1_result  out  37  same packing as s0_result.
REQ-009 w_req  in  1  write request (tlbwr).
REQ-010 fill_req  in  1  write request (tlbfill), index from internal pointer.
REQ-011 w_index  in  4  tlbwr target index.
REQ-012 w_entry  in  89  {e, vppn[18:0], ps[5:0], asid[9:0], g, ppn0[19:0], plv0, mat0, d0, v0, ppn1[19:0], plv1, mat1, d1, v1}.
REQ-013 w_ready  out  1  write port can accept; equals inv_ready.
REQ-014 r_index  in  4  tlbrd index; r_entry  out  89  same packing as w_entry.
REQ-015 inv_valid/inv_op/inv_asid/inv_vppn  in  1/5/10/19  invtlb request.
REQ-016 inv_ready  out  1  high only in IDLE.
REQ-017 inv_done  out  1  one-cycle completion pulse.

Function
REQ-018 Searches SHALL be combinational on current array; entry i matches when e && (g || asid==key_asid) && (ps==12 ? vppn==key_vppn : vppn[18:9]==key_vppn[18:9]).
REQ-019 Page half SHALL be selected by (ps==12 ? va_bit12 : vppn[8]): 0 -> ppn0/plv0/mat0/d0/v0, 1 -> *1 fields.
REQ-020 Multiple hits: lowest index wins; no hit: all result fields 0.
REQ-021 r_entry SHALL be combinational read of entry[r_index].
REQ-022 Write SHALL commit at the edge where (w_req||fill_req) && w_ready; fill_req has priority over w_req if both high.
REQ-023 Fill index SHALL be a 4-bit round-robin pointer, incremented modulo 16 on each accepted fill, wrapping 15->0.
REQ-024 Writes with w_ready low SHALL be ignored (no entry or pointer change).
REQ-025 Invalidate FSM states: IDLE, SWEEP, DONE.
REQ-026 IDLE -> SWEEP when inv_valid && op<=6: latch op/asid/vppn, sweep pointer=0.
REQ-027 IDLE with inv_valid && op>6: go DONE directly, no entry modified.
REQ-028 SWEEP: each cycle evaluate entry[ptr], clear its e bit on match, ptr++; after ptr==15 go DONE.
REQ-029 DONE: inv_done=1 for exactly one cycle, return to IDLE.
REQ-030 Match per op: 0,1 all; 2 g==1; 3 g==0; 4 g==0 && asid eq; 5 g==0 && asid eq && vppn eq; 6 (g==1 || asid eq) && vppn eq; vppn eq uses REQ-018 ps rule.
REQ-031 Latency: request accepted at edge T; entry k cleared at edge T+1+k; inv_done high in cycle after edge T+16.
REQ-032 Write and invalidate accepted at same IDLE edge: write commits first; sweep sees written entry.
REQ-033 Searches SHALL remain serviced during SWEEP, reflecting entries cleared so far.

Reset
REQ-034 resetn low SHALL asynchronously clear all entry fields to 0, fill pointer 0, sweep pointer 0, FSM IDLE.
REQ-035 Reset outputs: inv_done=0, inv_ready=1, w_ready=1, s0/s1_result=0.
REQ-036 Reset mid-sweep SHALL abort immediately; no inv_done pulse.

Verification
REQ-037 Write idx 3 {e=1,vppn=0x12345,ps=12,asid=5,g=0,ppn0=0xAAAAA,v0=1}; s0 key (0x12345,0,5) -> found=1,index=3,ppn=0xAAAAA,v=1; asid=6 -> found=0.
REQ-038 Entries 2 and 7 identical g=1 ps=21; search any asid with matching vppn[18:9], bit8=1 -> index=2, ppn1 fields.
REQ-039 Four fill_req after reset -> entries 0,1,2,3 written; 17th fill writes index 0 again.
REQ-040 Fill all 16 g=0 asid=5, inv op=4 asid=5 at edge T -> inv_ready low T+1..T+17, inv_done at cycle after T+16, all e=0; w_req during busy ignored.
REQ-041 inv op=9 -> inv_done next cycle, array unchanged; op=2 with entries g={1,0} -> only g=1 cleared.
REQ-042 Assert resetn low at sweep ptr=8 -> all e=0, inv_ready=1, no inv_done.
